// File: rtl/hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit
//
// Producer-side hazard detector for a five-stage pipeline with branches
// resolved in ID. It catches the read-after-write hazards that the EX/ID
// forwarding network cannot cover. It stalls the front end by holding the PC
// and IF/ID and bubbling ID/EX. It also flushes IF/ID on taken branches.
// Multi-cycle stalls (a load feeding a branch) come from a two-state FSM
// with a small down-counter. Two saturating counters expose stall and flush
// activity.
//
// Ports:
//   Clk, Rst            clock; synchronous active-low reset
//   RS_ID, RT_ID        source specifiers of the instruction in ID
//   UsesRS_ID/RT_ID     ID instruction actually reads rs / rt
//   Branch_ID           ID instruction is a branch compared in ID
//   BranchTaken_ID      ID compare result (meaningful only with Branch_ID)
//   RD_EX, RegWrite_EX, MemRead_EX   destination / write / load flags in EX
//   RD_MEM, MemRead_MEM              destination / load flag in MEM
//   PCWrite, IF_ID_Write             front-end enables (low while stalling)
//   ID_EX_Bubble                     zero ID/EX control this cycle
//   IF_ID_Flush                      clear IF/ID on the next edge
//   Stalling                         ~PCWrite, for visibility
//   StallCycles, FlushCount          saturating performance counters
// ---------------------------------------------------------------------------
module hazard_stall_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [REG_W-1:0] RS_ID,
    input  logic [REG_W-1:0] RT_ID,
    input  logic             UsesRS_ID,
    input  logic             UsesRT_ID,
    input  logic             Branch_ID,
    input  logic             BranchTaken_ID,
    input  logic [REG_W-1:0] RD_EX,
    input  logic             RegWrite_EX,
    input  logic             MemRead_EX,
    input  logic [REG_W-1:0] RD_MEM,
    input  logic             MemRead_MEM,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Bubble,
    output logic             IF_ID_Flush,
    output logic             Stalling,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);

    typedef enum logic {IDLE, STALL} state_t;

    state_t     state;
    logic [1:0] remain;

    logic       match_ex;
    logic       match_mem;
    logic [1:0] depth;
    logic       stall_now;
    logic       flush_now;

    always_comb begin
        // Register 0 is hard-wired, so it can never carry a dependence.
        match_ex  = (RD_EX != '0) &&
                    ((UsesRS_ID && (RD_EX == RS_ID)) ||
                     (UsesRT_ID && (RD_EX == RT_ID)));
        match_mem = (RD_MEM != '0) &&
                    ((UsesRS_ID && (RD_MEM == RS_ID)) ||
                     (UsesRT_ID && (RD_MEM == RT_ID)));

        // Hazard depth is only meaningful in IDLE; STALL ignores new hazards.
        depth = 2'd0;
        if (state == IDLE) begin
            if (MemRead_EX && match_ex && Branch_ID)
                depth = 2'd2;
            else if (MemRead_EX && match_ex)
                depth = 2'd1;
            else if (Branch_ID && RegWrite_EX && !MemRead_EX && match_ex)
                depth = 2'd1;
            else if (Branch_ID && MemRead_MEM && match_mem)
                depth = 2'd1;
        end

        // Gating with Rst keeps the front end running while reset is held,
        // even if the FSM is still in STALL before the reset edge.
        stall_now = Rst && ((state == STALL) || (depth != 2'd0));

        // A stalled branch re-resolves once the stall ends, so no flush now.
        // Branch_ID is evaluated first so it masks an undriven taken flag.
        flush_now = Rst && Branch_ID && BranchTaken_ID && !stall_now;

        PCWrite      = !stall_now;
        IF_ID_Write  = !stall_now;
        ID_EX_Bubble = stall_now;
        Stalling     = stall_now;
        IF_ID_Flush  = flush_now;
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state       <= IDLE;
            remain      <= 2'd0;
            StallCycles <= '0;
            FlushCount  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A depth-1 stall finishes in this cycle and needs no FSM help.
                    if (depth == 2'd2) begin
                        remain <= 2'd1;
                        state  <= STALL;
                    end
                end
                STALL: begin
                    remain <= remain - 2'd1;
                    if (remain == 2'd1)
                        state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    remain <= 2'd0;
                end
            endcase

            if (stall_now && (StallCycles != '1))
                StallCycles <= StallCycles + CNT_W'(1);
            if (flush_now && (FlushCount != '1))
                FlushCount <= FlushCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_unit
//
// Directed bench for hazard_stall_unit. A default-width instance and a 4-bit
// counter instance share the same stimulus. The narrow instance exercises
// counter saturation. Inputs change 1 time unit after a rising edge.
// Combinational outputs are sampled 1 unit later, and registered counters
// are sampled after the following edge.
// ---------------------------------------------------------------------------
module tb_hazard_stall_unit;

    localparam int REG_W = 5;

    logic             Clk = 1'b0;
    logic             Rst;
    logic [REG_W-1:0] RS_ID, RT_ID, RD_EX, RD_MEM;
    logic             UsesRS_ID, UsesRT_ID, Branch_ID, BranchTaken_ID;
    logic             RegWrite_EX, MemRead_EX, MemRead_MEM;

    logic        PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Stalling;
    logic [15:0] StallCycles, FlushCount;

    logic        s_PCWrite, s_IF_ID_Write, s_ID_EX_Bubble, s_IF_ID_Flush, s_Stalling;
    logic [3:0]  s_StallCycles, s_FlushCount;

    int vectors = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    hazard_stall_unit #(.REG_W(REG_W), .CNT_W(16)) dut (
        .Clk(Clk), .Rst(Rst),
        .RS_ID(RS_ID), .RT_ID(RT_ID), .UsesRS_ID(UsesRS_ID), .UsesRT_ID(UsesRT_ID),
        .Branch_ID(Branch_ID), .BranchTaken_ID(BranchTaken_ID),
        .RD_EX(RD_EX), .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX),
        .RD_MEM(RD_MEM), .MemRead_MEM(MemRead_MEM),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Bubble(ID_EX_Bubble),
        .IF_ID_Flush(IF_ID_Flush), .Stalling(Stalling),
        .StallCycles(StallCycles), .FlushCount(FlushCount)
    );

    hazard_stall_unit #(.REG_W(REG_W), .CNT_W(4)) dut_sat (
        .Clk(Clk), .Rst(Rst),
        .RS_ID(RS_ID), .RT_ID(RT_ID), .UsesRS_ID(UsesRS_ID), .UsesRT_ID(UsesRT_ID),
        .Branch_ID(Branch_ID), .BranchTaken_ID(BranchTaken_ID),
        .RD_EX(RD_EX), .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX),
        .RD_MEM(RD_MEM), .MemRead_MEM(MemRead_MEM),
        .PCWrite(s_PCWrite), .IF_ID_Write(s_IF_ID_Write), .ID_EX_Bubble(s_ID_EX_Bubble),
        .IF_ID_Flush(s_IF_ID_Flush), .Stalling(s_Stalling),
        .StallCycles(s_StallCycles), .FlushCount(s_FlushCount)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        RS_ID = '0; RT_ID = '0; RD_EX = '0; RD_MEM = '0;
        UsesRS_ID = 1'b0; UsesRT_ID = 1'b0; Branch_ID = 1'b0; BranchTaken_ID = 1'b0;
        RegWrite_EX = 1'b0; MemRead_EX = 1'b0; MemRead_MEM = 1'b0;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // All four front-end outputs follow from one expected stall bit.
    task automatic check_stall(input string tag, input logic exp_stall);
        #1;
        check_eq({tag, "_pcw"},    32'(PCWrite),      32'(!exp_stall));
        check_eq({tag, "_ifidw"},  32'(IF_ID_Write),  32'(!exp_stall));
        check_eq({tag, "_bubble"}, 32'(ID_EX_Bubble), 32'(exp_stall));
        check_eq({tag, "_stall"},  32'(Stalling),     32'(exp_stall));
    endtask

    initial begin
        Rst = 1'b0;
        clear_inputs();
        step();
        step();

        // Reset held with a load-use hazard and a taken branch on the inputs.
        MemRead_EX = 1'b1; RD_EX = 5'd5; RS_ID = 5'd5; UsesRS_ID = 1'b1;
        Branch_ID = 1'b1; BranchTaken_ID = 1'b1;
        check_stall("in_reset", 1'b0);
        check_eq("in_reset_flush", 32'(IF_ID_Flush), 32'd0);
        step();
        check_eq("rst_stallcnt", 32'(StallCycles), 32'd0);
        check_eq("rst_flushcnt", 32'(FlushCount), 32'd0);

        Rst = 1'b1;
        clear_inputs();
        check_stall("idle", 1'b0);
        step();

        // Load-use: exactly one stall cycle.
        MemRead_EX = 1'b1; RD_EX = 5'd5; RS_ID = 5'd5; UsesRS_ID = 1'b1;
        check_stall("lu_c1", 1'b1);
        step();
        check_eq("lu_cnt1", 32'(StallCycles), 32'd1);
        MemRead_EX = 1'b0; RD_EX = 5'd0; MemRead_MEM = 1'b1; RD_MEM = 5'd5;
        check_stall("lu_c2", 1'b0);
        step();
        check_eq("lu_cnt2", 32'(StallCycles), 32'd1);

        // Load feeding a taken branch: two stalls, flush held off until release.
        clear_inputs();
        MemRead_EX = 1'b1; RD_EX = 5'd8; RT_ID = 5'd8; UsesRT_ID = 1'b1;
        Branch_ID = 1'b1; BranchTaken_ID = 1'b1;
        check_stall("lb_c1", 1'b1);
        check_eq("lb_c1_flush", 32'(IF_ID_Flush), 32'd0);
        step();
        MemRead_EX = 1'b0; RD_EX = 5'd0; MemRead_MEM = 1'b1; RD_MEM = 5'd8;
        check_stall("lb_c2", 1'b1);
        check_eq("lb_c2_flush", 32'(IF_ID_Flush), 32'd0);
        step();
        check_eq("lb_cnt", 32'(StallCycles), 32'd3);
        MemRead_MEM = 1'b0; RD_MEM = 5'd0;
        check_stall("lb_c3", 1'b0);
        check_eq("lb_c3_flush", 32'(IF_ID_Flush), 32'd1);
        step();
        check_eq("lb_flushcnt", 32'(FlushCount), 32'd1);
        check_eq("lb_cnt_after", 32'(StallCycles), 32'd3);

        // ALU result feeding a branch: one stall, then the taken flush.
        clear_inputs();
        RegWrite_EX = 1'b1; RD_EX = 5'd3; RS_ID = 5'd3; UsesRS_ID = 1'b1;
        Branch_ID = 1'b1; BranchTaken_ID = 1'b1;
        check_stall("alu_c1", 1'b1);
        check_eq("alu_c1_flush", 32'(IF_ID_Flush), 32'd0);
        step();
        RegWrite_EX = 1'b0; RD_EX = 5'd0;
        check_stall("alu_c2", 1'b0);
        check_eq("alu_c2_flush", 32'(IF_ID_Flush), 32'd1);
        step();
        check_eq("alu_flushcnt", 32'(FlushCount), 32'd2);
        check_eq("alu_stallcnt", 32'(StallCycles), 32'd4);

        // Combinational-only cases; no clock edge is taken between them.
        clear_inputs();
        MemRead_EX = 1'b1; RD_EX = 5'd0; RS_ID = 5'd0; UsesRS_ID = 1'b1;
        check_stall("zero_reg", 1'b0);
        UsesRS_ID = 1'b0; RD_EX = 5'd4; RT_ID = 5'd4; UsesRT_ID = 1'b0;
        check_stall("unused_rt", 1'b0);
        UsesRT_ID = 1'b1;
        check_stall("used_rt", 1'b1);
        clear_inputs();
        MemRead_MEM = 1'b1; RD_MEM = 5'd9; RS_ID = 5'd9; UsesRS_ID = 1'b1;
        check_stall("mem_load_nobr", 1'b0);
        Branch_ID = 1'b1;
        check_stall("mem_load_br", 1'b1);
        clear_inputs();
        RegWrite_EX = 1'b1; RD_EX = 5'd6; RS_ID = 5'd6; UsesRS_ID = 1'b1;
        check_stall("alu_nobr", 1'b0);
        clear_inputs();
        BranchTaken_ID = 1'b1;
        check_eq("taken_masked", 32'(IF_ID_Flush), 32'd0);
        clear_inputs();

        // Reset asserted during the second cycle of a two-cycle stall.
        MemRead_EX = 1'b1; RD_EX = 5'd8; RT_ID = 5'd8; UsesRT_ID = 1'b1; Branch_ID = 1'b1;
        check_stall("rs_c1", 1'b1);
        step();
        clear_inputs();
        Rst = 1'b0;
        check_stall("rs_c2", 1'b0);
        step();
        Rst = 1'b1;
        check_stall("rs_after", 1'b0);
        check_eq("rs_stallcnt", 32'(StallCycles), 32'd0);
        check_eq("rs_flushcnt", 32'(FlushCount), 32'd0);
        check_eq("rs_sat_cnt", 32'(s_StallCycles), 32'd0);

        // Twenty consecutive one-cycle load-use hazards.
        MemRead_EX = 1'b1; RD_EX = 5'd7; RS_ID = 5'd7; UsesRS_ID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 14) check_eq("sat_at15", 32'(s_StallCycles), 32'd15);
        end
        check_eq("sat_hold", 32'(s_StallCycles), 32'd15);
        check_eq("wide_20", 32'(StallCycles), 32'd20);
        check_stall("sat_still", 1'b1);
        clear_inputs();
        step();
        check_eq("sat_final", 32'(s_StallCycles), 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Producer-side counterpart of the EX/ID forwarding logic: detects RAW hazards that forwarding cannot cover and stalls or flushes the front end.
- Drives PC and IF/ID write enables, inserts ID/EX bubbles, and flushes IF/ID on taken branches resolved in ID.
- Uses a small stall FSM with a down-counter for multi-cycle stalls, plus saturating performance counters.

Parameters:
- REG_W, 5, register specifier width.
- CNT_W, 16, width of each saturating performance counter.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Rst  in  1  synchronous, active-low reset, sampled on the Clk rising edge.
- RS_ID  in  REG_W  rs of the instruction in ID.
- RT_ID  in  REG_W  rt of the instruction in ID.
- UsesRS_ID  in  1  ID instruction reads rs.
- UsesRT_ID  in  1  ID instruction reads rt.
- Branch_ID  in  1  ID instruction is a branch whose compare runs in ID.
- BranchTaken_ID  in  1  ID compare result is taken; valid only when Branch_ID=1.
- RD_EX  in  REG_W  destination of the instruction in EX.
- RegWrite_EX  in  1  EX instruction writes a register.
- MemRead_EX  in  1  EX instruction is a load.
- RD_MEM  in  REG_W  destination of the instruction in MEM.
- MemRead_MEM  in  1  MEM instruction is a load.
- PCWrite  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID register enable.
- ID_EX_Bubble  out  1  zero the ID/EX control fields this cycle.
- IF_ID_Flush  out  1  clear IF/ID on the next edge (taken branch).
- Stalling  out  1  equals ~PCWrite; debug/visibility.
- StallCycles  out  CNT_W  count of stall cycles, saturating.
- FlushCount  out  CNT_W  count of taken-branch flushes, saturating.

Behaviour:
- Match definitions:
  - matchEX = RD_EX!=0 && ((UsesRS_ID && RD_EX==RS_ID) || (UsesRT_ID && RD_EX==RT_ID)).
  - matchMEM is the same test using RD_MEM.
- Hazard depth d, evaluated in IDLE only. Take the first rule that applies:
  - MemRead_EX && matchEX && Branch_ID → d=2.
  - MemRead_EX && matchEX → d=1.
  - Branch_ID && RegWrite_EX && !MemRead_EX && matchEX → d=1.
  - Branch_ID && MemRead_MEM && matchMEM → d=1.
  - Otherwise d=0.
- FSM states are IDLE and STALL; a REMAIN counter holds 2 bits.
  - IDLE with d=0: no stall.
  - IDLE with d=1: stall this cycle; next state IDLE; REMAIN stays 0.
  - IDLE with d=2: stall this cycle; REMAIN<=1; next state STALL.
  - STALL: stall this cycle and do not evaluate hazards. REMAIN<=REMAIN-1. Go to IDLE when REMAIN==1. Hazards are re-evaluated in IDLE on the following cycle.
- Stall cycle outputs (combinational from state and inputs):
  - PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, Stalling=1.
  - Non-stall cycles: PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0.
- IF_ID_Flush = Branch_ID && BranchTaken_ID && !stall_this_cycle.
  - A stall suppresses the flush; the branch re-resolves once the stall ends.
  - The flush never coincides with IF_ID_Write=0.
- Counters:
  - StallCycles increments on every stall cycle.
  - FlushCount increments on every cycle with IF_ID_Flush=1.
  - Both saturate at all-ones and never wrap.
- Reset (Rst=0 at an edge):
  - state=IDLE, REMAIN=0, counters=0.
  - During and after reset the outputs must read PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush=0, Stalling=0.
  - Reset asserted mid-STALL aborts the stall in the same edge.
- Register 0 never causes a hazard, regardless of write/read flags.
- X-free: Branch_ID=0 masks BranchTaken_ID.

Test Plan:
- Load-use: MemRead_EX=1, RD_EX=5, RS_ID=5, UsesRS_ID=1, Branch_ID=0 → exactly 1 cycle with PCWrite=0 and ID_EX_Bubble=1, then PCWrite=1. StallCycles 0→1.
- Load feeding a branch: MemRead_EX=1, RD_EX=8, RT_ID=8, UsesRT_ID=1, Branch_ID=1; then hold MemRead_MEM=1, RD_MEM=8 → 2 consecutive stall cycles (the STALL state must not re-trigger a third), then release. StallCycles=2.
- ALU result feeding a branch: RegWrite_EX=1, MemRead_EX=0, RD_EX=3, RS_ID=3, Branch_ID=1 → 1 stall. The next cycle, with BranchTaken_ID=1 and no hazard, gives IF_ID_Flush=1 and FlushCount=1.
- Zero register and unused source: RD_EX=0 with MemRead_EX=1 and RS_ID=0 → no stall. RD_EX=4, RT_ID=4, UsesRT_ID=0 → no stall.
- Reset mid-stall: enter the d=2 case and drive Rst=0 at the second cycle → the next cycle shows state IDLE, PCWrite=1, StallCycles=0.
- Saturation: with CNT_W=4, apply 20 consecutive d=1 hazards → StallCycles holds at 15.
